// File: rtl/run_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : run_ctrl_pkg
//  Description : Shared constants for run_ctrl: FSM state encoding,
//                button-event priority codes and auto-repeat timing.
//  Revision    : 1.0  initial release
// ============================================================================
package run_ctrl_pkg;

    // FSM state encoding (also exported on ctrl_state)
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LOADWAIT = 3'd1;
    localparam logic [2:0] S_READY    = 3'd2;
    localparam logic [2:0] S_RUN      = 3'd3;
    localparam logic [2:0] S_STEP     = 3'd4;

    // Winning button event of a cycle; load beats run beats step
    localparam logic [1:0] c_EV_NONE = 2'd0;
    localparam logic [1:0] c_EV_LOAD = 2'd1;
    localparam logic [1:0] c_EV_RUN  = 2'd2;
    localparam logic [1:0] c_EV_STEP = 2'd3;

    // Auto-repeat: hold time before repeating, and repeat period (log2 cycles)
    localparam int AUTO_HOLD_LOG2 = 20;
    localparam int AUTO_RATE_LOG2 = 18;

    // Collapse simultaneous edges into the single highest-priority event
    function automatic logic [1:0] pick_event(input logic ev_load,
                                              input logic ev_run,
                                              input logic ev_step);
        if (ev_load)      return c_EV_LOAD;
        else if (ev_run)  return c_EV_RUN;
        else if (ev_step) return c_EV_STEP;
        else              return c_EV_NONE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/edge_pulse.sv
`default_nettype none
// ============================================================================
//  Module      : edge_pulse
//  Description : Rising-edge detector for one debounced button level.
//                The history bit resets to 1 so a button held through
//                reset produces no edge.
//  Revision    : 1.0  initial release
// ============================================================================
module edge_pulse (
    input  logic CLK,
    input  logic reset,
    input  logic level,
    output logic rise
);

    logic r_last;

    // Remember the previous level every cycle
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) r_last <= 1'b1;
        else       r_last <= level;
    end

    assign rise = level & ~r_last;

endmodule
`default_nettype wire

// File: rtl/run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : run_ctrl
//  Description : Turns debounced run/step/load buttons into single-cycle
//                requests for cpu_core, tracks load/run/single-step phases
//                and flags a load timeout.
//                Optional macro RUN_CTRL_AUTOREPEAT_EN: holding the step
//                button in STEP auto-repeats step requests.
//  Revision    : 1.0  initial release
// ============================================================================
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int                CNT_W        = 24,
    parameter logic [CNT_W-1:0]  LOAD_TIMEOUT = 24'd12_000_000
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       btn_run,
    input  logic       btn_step,
    input  logic       btn_load,
    input  logic       core_loaded,
    input  logic       core_executing,
    input  logic       core_step_wait,
    output logic       start_req,
    output logic       step_req,
    output logic       load_req,
    output logic       step_mode,
    output logic       load_err,
    output logic [2:0] ctrl_state
);

    localparam logic [CNT_W-1:0] c_TIMEOUT_LAST = LOAD_TIMEOUT - 1'b1;
    localparam logic [CNT_W-1:0] c_CNT_MAX      = {CNT_W{1'b1}};
    localparam logic [1:0]       c_GUARD_DONE   = 2'd2;

    // ------------------------------------------------------------------
    // Button edge detection
    // ------------------------------------------------------------------
    logic w_ev_run, w_ev_step, w_ev_load;
    logic [1:0] w_ev;

    edge_pulse u_edge_run  (.CLK(CLK), .reset(reset), .level(btn_run),  .rise(w_ev_run));
    edge_pulse u_edge_step (.CLK(CLK), .reset(reset), .level(btn_step), .rise(w_ev_step));
    edge_pulse u_edge_load (.CLK(CLK), .reset(reset), .level(btn_load), .rise(w_ev_load));

    assign w_ev = pick_event(w_ev_load, w_ev_run, w_ev_step);

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    logic [2:0]       r_state, w_state_nxt;
    logic             r_start_req, r_step_req, r_load_req;
    logic             r_step_mode, r_load_err;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_guard;   // cycles since entering RUN/STEP, saturates at 2

    logic             w_start_nxt, w_step_nxt, w_load_nxt;
    logic             w_mode_nxt, w_err_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [1:0]       w_guard_nxt;

    logic w_auto_step;

    // ------------------------------------------------------------------
    // Decisions shared by next-state and output logic
    // ------------------------------------------------------------------
    logic w_in_exec, w_finished, w_loaded, w_timeout;
    logic w_do_load, w_do_start, w_do_step, w_toggle;

    assign w_in_exec  = (r_state == S_RUN) || (r_state == S_STEP);
    // Program end only trusted once the core has had time to start
    assign w_finished = w_in_exec && (r_guard == c_GUARD_DONE) && !core_executing;
    assign w_loaded   = (r_state == S_LOADWAIT) && core_loaded;
    assign w_timeout  = (r_state == S_LOADWAIT) && !core_loaded && (r_cnt == c_TIMEOUT_LAST);
    assign w_do_load  = (w_ev == c_EV_LOAD) && ((r_state == S_IDLE) || (r_state == S_READY));
    assign w_do_start = (w_ev == c_EV_RUN)  && ((r_state == S_READY) ||
                                                ((r_state == S_STEP) && !w_finished));
    assign w_do_step  = !w_finished &&
                        (((r_state == S_RUN)  && (w_ev == c_EV_STEP)) ||
                         ((r_state == S_STEP) && (((w_ev == c_EV_STEP) && core_step_wait) ||
                                                  w_auto_step)));
    assign w_toggle   = (r_state == S_READY) && (w_ev == c_EV_STEP);

    // State register
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:     if (w_do_load) w_state_nxt = S_LOADWAIT;
            S_LOADWAIT: begin
                if (w_loaded)       w_state_nxt = S_READY;
                else if (w_timeout) w_state_nxt = S_IDLE;
            end
            S_READY: begin
                if (w_do_load)       w_state_nxt = S_LOADWAIT;
                else if (w_do_start) w_state_nxt = r_step_mode ? S_STEP : S_RUN;
            end
            S_RUN: begin
                if (w_finished)     w_state_nxt = S_READY;
                else if (w_do_step) w_state_nxt = S_STEP;
            end
            S_STEP: begin
                if (w_finished)      w_state_nxt = S_READY;
                else if (w_do_start) w_state_nxt = S_RUN;
            end
            default:                 w_state_nxt = S_IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        w_start_nxt = w_do_start;
        w_step_nxt  = w_do_step;
        w_load_nxt  = w_do_load;
        w_mode_nxt  = w_toggle ? ~r_step_mode : r_step_mode;
        w_err_nxt   = r_load_err;
        if (w_do_load)      w_err_nxt = 1'b0;
        else if (w_timeout) w_err_nxt = 1'b1;
        w_cnt_nxt = r_cnt;
        if (w_do_load)
            w_cnt_nxt = '0;
        else if ((r_state == S_LOADWAIT) && !core_loaded && !w_timeout && (r_cnt != c_CNT_MAX))
            w_cnt_nxt = r_cnt + 1'b1;
        w_guard_nxt = r_guard;
        if (w_state_nxt != r_state)      w_guard_nxt = 2'd0;
        else if (r_guard != c_GUARD_DONE) w_guard_nxt = r_guard + 2'd1;
    end

    // Request pulses, flags and counters
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_start_req <= 1'b0;
            r_step_req  <= 1'b0;
            r_load_req  <= 1'b0;
            r_step_mode <= 1'b0;
            r_load_err  <= 1'b0;
            r_cnt       <= '0;
            r_guard     <= 2'd0;
        end else begin
            r_start_req <= w_start_nxt;
            r_step_req  <= w_step_nxt;
            r_load_req  <= w_load_nxt;
            r_step_mode <= w_mode_nxt;
            r_load_err  <= w_err_nxt;
            r_cnt       <= w_cnt_nxt;
            r_guard     <= w_guard_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Optional step auto-repeat
    // ------------------------------------------------------------------
`ifdef RUN_CTRL_AUTOREPEAT_EN
    logic [AUTO_HOLD_LOG2-1:0] r_hold;
    logic [AUTO_RATE_LOG2-1:0] r_rate;
    logic                      r_auto;
    logic                      w_ar_keep;

    // Any other event, release, or leaving STEP cancels the repeat
    assign w_ar_keep   = (r_state == S_STEP) && btn_step && (w_ev == c_EV_NONE);
    assign w_auto_step = r_auto && (r_rate == {AUTO_RATE_LOG2{1'b1}}) && core_step_wait;

    // Hold timer arms repeat; rate timer then paces it
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_hold <= '0;
            r_rate <= '0;
            r_auto <= 1'b0;
        end else if (!w_ar_keep) begin
            r_hold <= '0;
            r_rate <= '0;
            r_auto <= 1'b0;
        end else if (!r_auto) begin
            if (r_hold == {AUTO_HOLD_LOG2{1'b1}}) r_auto <= 1'b1;
            else                                  r_hold <= r_hold + 1'b1;
        end else begin
            r_rate <= r_rate + 1'b1;
        end
    end
`else
    assign w_auto_step = 1'b0;
`endif

    assign start_req  = r_start_req;
    assign step_req   = r_step_req;
    assign load_req   = r_load_req;
    assign step_mode  = r_step_mode;
    assign load_err   = r_load_err;
    assign ctrl_state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_run_ctrl
//  Description : Directed, table-driven bench for run_ctrl. Each row holds
//                inputs for n cycles, then compares
//                {start_req,step_req,load_req,step_mode,load_err,ctrl_state}.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_run_ctrl;

    localparam int c_TIMEOUT = 120;

    logic       CLK = 1'b0;
    logic       reset;
    logic       btn_run, btn_step, btn_load;
    logic       core_loaded, core_executing, core_step_wait;
    logic       start_req, step_req, load_req, step_mode, load_err;
    logic [2:0] ctrl_state;

    run_ctrl #(.CNT_W(24), .LOAD_TIMEOUT(24'(c_TIMEOUT))) dut (
        .CLK(CLK), .reset(reset),
        .btn_run(btn_run), .btn_step(btn_step), .btn_load(btn_load),
        .core_loaded(core_loaded), .core_executing(core_executing),
        .core_step_wait(core_step_wait),
        .start_req(start_req), .step_req(step_req), .load_req(load_req),
        .step_mode(step_mode), .load_err(load_err), .ctrl_state(ctrl_state)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       run, step, load, loaded, exec, swait;
        int         n;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    function automatic void add(input logic run, step, load, loaded, exec, swait,
                                input int n,
                                input logic e_start, e_step, e_load, e_mode, e_err,
                                input logic [2:0] e_st);
        vec_t v;
        v.run = run; v.step = step; v.load = load;
        v.loaded = loaded; v.exec = exec; v.swait = swait;
        v.n = n;
        v.exp = {e_start, e_step, e_load, e_mode, e_err, e_st};
        vecs.push_back(v);
    endfunction

    task automatic check(input string nm, input logic [7:0] exp);
        logic [7:0] act;
        act = {start_req, step_req, load_req, step_mode, load_err, ctrl_state};
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got start/step/load/mode/err/state=%b want %b", nm, act, exp);
        end
    endtask

    initial begin
        //  run step load ldd exec sw  n     start step load mode err st
        add(0, 0, 1, 0, 0, 0,   1,   0, 0, 0, 0, 0, 3'd0);  // held through reset: no pulse
        add(0, 0, 0, 0, 0, 0,   1,   0, 0, 0, 0, 0, 3'd0);
        add(0, 0, 1, 0, 0, 0,   1,   0, 0, 1, 0, 0, 3'd1);  // load press
        add(0, 0, 0, 0, 0, 0, 100,   0, 0, 0, 0, 0, 3'd1);  // waiting for core
        add(0, 0, 0, 1, 0, 0,   1,   0, 0, 0, 0, 0, 3'd2);  // loaded -> READY
        add(0, 0, 0, 0, 0, 0,   1,   0, 0, 0, 0, 0, 3'd2);
        add(1, 0, 1, 0, 0, 0,   1,   0, 0, 1, 0, 0, 3'd1);  // load+run: load only
        add(0, 0, 0, 0, 0, 0,   1,   0, 0, 0, 0, 0, 3'd1);
        add(0, 0, 0, 0, 0, 0, c_TIMEOUT-2, 0, 0, 0, 0, 0, 3'd1);  // last LOADWAIT cycle
        add(0, 0, 0, 0, 0, 0,   1,   0, 0, 0, 0, 1, 3'd0);  // timeout
        add(0, 0, 1, 0, 0, 0,   1,   0, 0, 1, 0, 0, 3'd1);  // reload clears err
        add(0, 0, 0, 1, 0, 0,   1,   0, 0, 0, 0, 0, 3'd2);
        add(1, 0, 0, 0, 1, 0,   1,   1, 0, 0, 0, 0, 3'd3);  // free run
        add(0, 0, 0, 0, 1, 0,   9,   0, 0, 0, 0, 0, 3'd3);
        add(0, 0, 0, 0, 0, 0,   1,   0, 0, 0, 0, 0, 3'd2);  // finished
        add(1, 0, 0, 0, 0, 0,   1,   1, 0, 0, 0, 0, 3'd3);  // run, exec already low
        add(0, 0, 0, 0, 0, 0,   1,   0, 0, 0, 0, 0, 3'd3);  // guard holds
        add(0, 0, 0, 0, 0, 0,   1,   0, 0, 0, 0, 0, 3'd3);  // guard holds
        add(0, 0, 0, 0, 0, 0,   1,   0, 0, 0, 0, 0, 3'd2);  // 2 cycles after start_req
        add(0, 1, 0, 0, 0, 0,   1,   0, 0, 0, 1, 0, 3'd2);  // step_mode on
        add(1, 0, 0, 0, 1, 0,   1,   1, 0, 0, 1, 0, 3'd4);  // run -> STEP
        add(0, 0, 0, 0, 1, 1,   1,   0, 0, 0, 1, 0, 3'd4);
        add(0, 1, 0, 0, 1, 1,   1,   0, 1, 0, 1, 0, 3'd4);  // step 1
        add(0, 0, 0, 0, 1, 1,   1,   0, 0, 0, 1, 0, 3'd4);
        add(0, 1, 0, 0, 1, 1,   1,   0, 1, 0, 1, 0, 3'd4);  // step 2
        add(0, 0, 0, 0, 1, 1,   1,   0, 0, 0, 1, 0, 3'd4);
        add(0, 1, 0, 0, 1, 1,   1,   0, 1, 0, 1, 0, 3'd4);  // step 3
        add(0, 0, 0, 0, 1, 1,   1,   0, 0, 0, 1, 0, 3'd4);
        add(0, 1, 0, 0, 1, 0,   1,   0, 0, 0, 1, 0, 3'd4);  // core not waiting: dropped
        add(0, 0, 0, 0, 1, 0,   1,   0, 0, 0, 1, 0, 3'd4);
        add(1, 0, 0, 0, 1, 0,   1,   1, 0, 0, 1, 0, 3'd3);  // resume -> RUN
        add(0, 0, 0, 0, 1, 0,   1,   0, 0, 0, 1, 0, 3'd3);  // step_mode persists
        add(0, 1, 0, 0, 1, 0,   1,   0, 1, 0, 1, 0, 3'd4);  // break into STEP
        add(0, 0, 0, 0, 1, 1,   1,   0, 0, 0, 1, 0, 3'd4);
        add(1, 0, 0, 0, 1, 1,   1,   1, 0, 0, 1, 0, 3'd3);  // start_req pending

        // Reset with load button already held
        reset = 1'b1;
        btn_run = 1'b0; btn_step = 1'b0; btn_load = 1'b1;
        core_loaded = 1'b0; core_executing = 1'b0; core_step_wait = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("reset_state", 8'h00);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            btn_run        = vecs[i].run;
            btn_step       = vecs[i].step;
            btn_load       = vecs[i].load;
            core_loaded    = vecs[i].loaded;
            core_executing = vecs[i].exec;
            core_step_wait = vecs[i].swait;
            repeat (vecs[i].n) @(posedge CLK);
            #1;
            check($sformatf("row%0d", i), vecs[i].exp);
        end

        // Asynchronous reset while start_req is high in RUN
        reset = 1'b1;
        #1;
        check("async_reset_now", 8'h00);
        @(posedge CLK);
        #1;
        check("async_reset_held", 8'h00);
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
